vuprs_adc_stream_packer: RTL and testbench

//  Downstream stage of the VUPRS ADC controller. Takes one parallel sample group per conversion
//  (CH_NUM channels x SMP_W bits), buffers it, serializes it onto an AXI4-Stream master and closes

---
 rtl/vuprs_adc_pkg.sv | 20 ++
 rtl/vuprs_adc_grp_fifo.sv | 54 +++++
 rtl/vuprs_adc_stream_packer.sv | 148 ++++++++++++++
 tb/tb_vuprs_adc_stream_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vuprs_adc_pkg.sv
// Shared types for the VUPRS ADC stream path.
// Group geometry, buffered group record, packer FSM states.
package vuprs_adc_pkg;

  localparam int ADC_CH_NUM = 8;
  localparam int ADC_SMP_W  = 16;
  localparam int ADC_AXIS_W = 32;
  localparam int ADC_GRP_W  = ADC_CH_NUM * ADC_SMP_W;

  typedef struct packed {
    logic [ADC_GRP_W-1:0] data;
    logic                 last;
  } adc_grp_t;

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_SEND = 1'b1
  } pk_state_e;

endpackage

// File: rtl/vuprs_adc_grp_fifo.sv
// First-word-fall-through group FIFO; push+pop allowed when full.
// Ports: clk, rst_n, push, wr_data, pop, rd_data, full, empty, count.
module vuprs_adc_grp_fifo
  import vuprs_adc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  adc_grp_t      wr_data,
  input  logic          pop,
  output adc_grp_t      rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  adc_grp_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vuprs_adc_stream_packer.sv
// Buffers ADC sample groups and serializes them onto AXI4-Stream.
// Ports: ACLK/ARESETN, cfg_*, smp_*, m_axis_*, sts_* status.
module vuprs_adc_stream_packer
  import vuprs_adc_pkg::*;
#(
  parameter int CH_NUM    = ADC_CH_NUM,
  parameter int SMP_W     = ADC_SMP_W,
  parameter int DATA_W    = ADC_AXIS_W,
  parameter int GRP_DEPTH = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_enable,
  input  logic [15:0]             cfg_frame_len,
  input  logic                    smp_valid,
  input  logic [CH_NUM*SMP_W-1:0] smp_data,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic [DATA_W/8-1:0]     m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    sts_busy,
  output logic [15:0]             sts_overflow_cnt,
  output logic [31:0]             sts_frame_cnt
);

  localparam int GRP_W = CH_NUM * SMP_W;
  localparam int BEATS = GRP_W / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(GRP_DEPTH + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  pk_state_e        state;
  logic [BW-1:0]    beat;
  logic [GRP_W-1:0] sh;
  logic             sh_last;
  logic [15:0]      cap_cnt;
  logic [15:0]      len_q;
  logic [15:0]      cfg_len;
  logic [15:0]      eff_len;
  adc_grp_t         wr_grp;
  adc_grp_t         rd_grp;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             hs;
  logic             last_beat;
  logic             pop;
  logic             push;
  logic             drop;
  logic             accepting;

  assign cfg_len   = (cfg_frame_len == '0) ? 16'd1 : cfg_frame_len;
  assign eff_len   = (cap_cnt == '0) ? cfg_len : len_q;
  assign accepting = (cap_cnt != '0) || cfg_enable;
  // A full FIFO still has room when the send side drains it this cycle.
  assign push      = smp_valid && accepting && (!full || pop);
  assign drop      = smp_valid && accepting && full && !pop;

  assign wr_grp.data = smp_data;
  assign wr_grp.last = (cap_cnt == eff_len - 16'd1);

  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_beat = (beat == LAST_BEAT);
  assign pop       = (state == PK_IDLE) ? !empty
                                        : (hs && last_beat && !empty);

  assign m_axis_tdata  = sh[DATA_W-1:0];
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = (state == PK_SEND);
  assign m_axis_tlast  = m_axis_tvalid && sh_last && last_beat;
  assign sts_busy      = (cap_cnt != '0) || (count != '0) || m_axis_tvalid;

  vuprs_adc_grp_fifo #(
    .DEPTH (GRP_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .push    (push),
    .wr_data (wr_grp),
    .pop     (pop),
    .rd_data (rd_grp),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cap_cnt <= '0;
      len_q   <= 16'd1;
    end else if (push) begin
      if (cap_cnt == '0) len_q <= cfg_len;
      cap_cnt <= wr_grp.last ? 16'd0 : cap_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= PK_IDLE;
      beat    <= '0;
      sh      <= '0;
      sh_last <= 1'b0;
    end else begin
      unique case (state)
        PK_IDLE: begin
          if (!empty) begin
            sh      <= rd_grp.data;
            sh_last <= rd_grp.last;
            beat    <= '0;
            state   <= PK_SEND;
          end
        end
        PK_SEND: begin
          if (hs) begin
            if (!last_beat) begin
              sh   <= sh >> DATA_W;
              beat <= beat + 1'b1;
            end else if (!empty) begin
              sh      <= rd_grp.data;
              sh_last <= rd_grp.last;
              beat    <= '0;
            end else begin
              sh      <= '0;
              sh_last <= 1'b0;
              beat    <= '0;
              state   <= PK_IDLE;
            end
          end
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sts_overflow_cnt <= '0;
      sts_frame_cnt    <= '0;
    end else begin
      if (drop && sts_overflow_cnt != 16'hFFFF)
        sts_overflow_cnt <= sts_overflow_cnt + 16'd1;
      if (hs && m_axis_tlast)
        sts_frame_cnt <= sts_frame_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_vuprs_adc_stream_packer.sv
// Scoreboard bench for the ADC stream packer.
// Expected beats are queued at drive time, checked at handshake.
module tb_vuprs_adc_stream_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_enable;
  logic [15:0]  cfg_frame_len;
  logic         smp_valid;
  logic [127:0] smp_data;
  logic [31:0]  tdata;
  logic [3:0]   tkeep;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         busy;
  logic [15:0]  ovf;
  logic [31:0]  frames;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  vuprs_adc_stream_packer dut (
    .ACLK             (clk),
    .ARESETN          (rst_n),
    .cfg_enable       (cfg_enable),
    .cfg_frame_len    (cfg_frame_len),
    .smp_valid        (smp_valid),
    .smp_data         (smp_data),
    .m_axis_tdata     (tdata),
    .m_axis_tkeep     (tkeep),
    .m_axis_tvalid    (tvalid),
    .m_axis_tready    (tready),
    .m_axis_tlast     (tlast),
    .sts_busy         (busy),
    .sts_overflow_cnt (ovf),
    .sts_frame_cnt    (frames)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_grp(logic [7:0] lo);
    logic [127:0] g;
    for (int k = 0; k < 8; k++) g[k*16 +: 16] = {8'(k + 1), lo};
    return g;
  endfunction

  task automatic send_grp(logic [127:0] g, bit acc, bit last);
    beat_t b;
    smp_data  = g;
    smp_valid = 1'b1;
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        b.d = g[k*32 +: 32];
        b.l = last && (k == 3);
        q.push_back(b);
      end
    end
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tvalid();
    for (int i = 0; i < 20 && !tvalid; i++) cyc(1);
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 300 && q.size() != 0; i++) cyc(1);
    check(tag, q.size(), 0);
    cyc(4);
  endtask

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (q.size() == 0) begin
        check("extra_beat", tvalid, 0);
      end else begin
        beat_t e;
        e = q.pop_front();
        check("tdata", tdata, e.d);
        check("tlast", tlast, e.l);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    cfg_enable    = 1'b0;
    cfg_frame_len = 16'd1;
    smp_valid     = 1'b0;
    smp_data      = '0;
    tready        = 1'b1;
    cyc(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tkeep", tkeep, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_frames", frames, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: two-group frame, free-running sink
    cfg_enable    = 1'b1;
    cfg_frame_len = 16'd2;
    send_grp(mk_grp(8'h01), 1, 0);
    wait_tvalid();
    check("t1_beat0", tdata, 32'h02010101);
    cyc(6);
    send_grp(mk_grp(8'h02), 1, 1);
    drain("t1_drain");
    check("t1_frames", frames, 1);
    check("t1_busy", busy, 0);

    // 2: back-pressure mid-group
    cfg_frame_len = 16'd1;
    send_grp(mk_grp(8'h11), 1, 1);
    wait_tvalid();
    cyc(1);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", tvalid, 1);
      check("t2_hold_data", tdata, q[0].d);
      check("t2_hold_last", tlast, q[0].l);
    end
    @(posedge clk); #1;
    tready = 1'b1;
    drain("t2_drain");
    check("t2_frames", frames, 2);

    // 3: stalled sink, five back-to-back groups
    tready = 1'b0;
    send_grp(mk_grp(8'h21), 1, 1);
    send_grp(mk_grp(8'h22), 1, 1);
    send_grp(mk_grp(8'h23), 1, 1);
    send_grp(mk_grp(8'h24), 0, 0);
    send_grp(mk_grp(8'h25), 0, 0);
    cyc(3);
    check("t3_ovf", ovf, 2);
    check("t3_busy", busy, 1);
    tready = 1'b1;
    drain("t3_drain");
    check("t3_frames", frames, 5);

    // 4: enable dropped inside an open frame
    cfg_frame_len = 16'd3;
    send_grp(mk_grp(8'h31), 1, 0);
    cfg_enable = 1'b0;
    cyc(7);
    send_grp(mk_grp(8'h32), 1, 0);
    cyc(7);
    send_grp(mk_grp(8'h33), 1, 1);
    cyc(7);
    send_grp(mk_grp(8'h34), 0, 0);
    drain("t4_drain");
    check("t4_ovf", ovf, 2);
    check("t4_frames", frames, 6);
    check("t4_busy", busy, 0);

    // 5: zero frame length, then overflow saturation
    cfg_enable    = 1'b1;
    cfg_frame_len = 16'd0;
    send_grp(mk_grp(8'h41), 1, 1);
    cyc(7);
    send_grp(mk_grp(8'h42), 1, 1);
    drain("t5a_drain");
    check("t5a_frames", frames, 8);
    tready = 1'b0;
    send_grp(mk_grp(8'h51), 1, 1);
    send_grp(mk_grp(8'h52), 1, 1);
    send_grp(mk_grp(8'h53), 1, 1);
    smp_data  = {$urandom, $urandom, $urandom, $urandom};
    smp_valid = 1'b1;
    cyc(65540);
    smp_valid = 1'b0;
    check("t5_ovf_sat", ovf, 16'hFFFF);
    tready = 1'b1;
    drain("t5b_drain");
    check("t5b_frames", frames, 11);

    // 6: asynchronous reset mid-beat
    tready        = 1'b0;
    cfg_frame_len = 16'd1;
    send_grp(mk_grp(8'h61), 1, 1);
    wait_tvalid();
    check("t6_pre_valid", tvalid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_tdata", tdata, 0);
    check("t6_tlast", tlast, 0);
    check("t6_tkeep", tkeep, 4'hF);
    check("t6_busy", busy, 0);
    check("t6_ovf", ovf, 0);
    check("t6_frames", frames, 0);
    q.delete();
    cyc(2);
    rst_n  = 1'b1;
    tready = 1'b1;
    cyc(1);
    check("t6_post_frames", frames, 0);
    send_grp(mk_grp(8'h71), 1, 1);
    drain("t6_drain");
    check("t6_new_frames", frames, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
